// File: rtl/puf_crp_trng_engine_if.sv
// Host/PUF-side bundle for puf_crp_trng_engine; the engine takes the slave view.
// When STABILITY_MASK_EN is defined the bundle also carries stable_mask.
interface puf_crp_trng_engine_if #(
    parameter int RESP_W     = 64,
    parameter int CHAL_W     = 64,
    parameter int MSB_W      = 16,
    parameter int RAW_BLK    = 64,
    parameter int MAX_ROUNDS = 1023
);
    localparam int OC_W  = $clog2(RAW_BLK + 1);
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);

    // Run handshake: start is honoured only while busy is low; resp_valid stays
    // high with resp_out/err/ones_count frozen until the cycle resp_ack is seen,
    // and drops on the following cycle.
    logic                     start;
    logic                     mode;
    logic [CHAL_W-1:0]        seed;
    logic [CHAL_W-MSB_W-1:0]  trng_lsb;
    logic                     puf_trig;
    logic [CHAL_W-1:0]        puf_chal_l;
    logic [CHAL_W-1:0]        puf_chal_r;
    logic                     puf_resp;
    logic                     busy;
    logic [RESP_W-1:0]        resp_out;
    logic                     resp_valid;
    logic                     resp_ack;
    logic                     err;
    logic [OC_W-1:0]          ones_count;
    logic [RND_W-1:0]         rounds;
    logic [3:0]               state_dbg;
`ifdef STABILITY_MASK_EN
    logic [RESP_W-1:0]        stable_mask;
`endif

    modport slave (
        input  start, mode, seed, trng_lsb, puf_resp, resp_ack,
`ifdef STABILITY_MASK_EN
        output stable_mask,
`endif
        output puf_trig, puf_chal_l, puf_chal_r, busy, resp_out, resp_valid,
        output err, ones_count, rounds, state_dbg
    );

    modport master (
        output start, mode, seed, trng_lsb, puf_resp, resp_ack,
`ifdef STABILITY_MASK_EN
        input  stable_mask,
`endif
        input  puf_trig, puf_chal_l, puf_chal_r, busy, resp_out, resp_valid,
        input  err, ones_count, rounds, state_dbg
    );
endinterface

// File: rtl/puf_crp_trng_engine.sv
// Delay-PUF controller: CRP mode (LFSR challenges, majority vote) and TRNG mode
// (von Neumann pairs, closed-loop bias tuning). STABILITY_MASK_EN adds stable_mask.
module puf_crp_trng_engine #(
    parameter int              RESP_W     = 64,
    parameter int              CHAL_W     = 64,
    parameter int              MSB_W      = 16,
    parameter int              ITER       = 10,
    parameter int              MAJ        = 5,
    parameter int              SETTLE     = 1,
    parameter logic [CHAL_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000,
    parameter int              RAW_BLK    = 64,
    parameter int              BIAS_HI    = 40,
    parameter int              BIAS_LO    = 30,
    parameter int              STEP       = 50,
    parameter int              MAX_ROUNDS = 1023
) (
    input  logic                   mclk,
    input  logic                   rst,
    puf_crp_trng_engine_if.slave   bus
);
    localparam int OC_W  = $clog2(RAW_BLK + 1);
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);
    localparam int IT_W  = $clog2(ITER + 1);
    localparam int BC_W  = $clog2(RESP_W + 1);
    localparam int RC_W  = $clog2(RAW_BLK + 1);
    localparam int ST_W  = $clog2(SETTLE + 1);

    localparam logic [IT_W-1:0]  ITER_C      = IT_W'(ITER);
    localparam logic [IT_W-1:0]  MAJ_C       = IT_W'(MAJ);
    localparam logic [BC_W-1:0]  RESP_C      = BC_W'(RESP_W);
    localparam logic [RC_W-1:0]  RAW_C       = RC_W'(RAW_BLK);
    localparam logic [OC_W-1:0]  BIAS_HI_C   = OC_W'(BIAS_HI);
    localparam logic [OC_W-1:0]  BIAS_LO_C   = OC_W'(BIAS_LO);
    localparam logic [RND_W-1:0] MAXR_C      = RND_W'(MAX_ROUNDS);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE - 1);
    localparam logic [MSB_W:0]   STEP_X      = (MSB_W + 1)'(STEP);
    localparam logic [MSB_W-1:0] STEP_M      = MSB_W'(STEP);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_TRIG   = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_SAMPLE = 4'd4;
    localparam logic [3:0] S_VOTE   = 4'd5;
    localparam logic [3:0] S_PAIR   = 4'd6;
    localparam logic [3:0] S_CHECK  = 4'd7;
    localparam logic [3:0] S_HOLD   = 4'd8;

    logic [3:0]        state;
    logic              run_crp;
    logic              run_trng;
    logic [CHAL_W-1:0] lfsr;
    logic [MSB_W-1:0]  l_msb;
    logic [MSB_W-1:0]  r_msb;
    logic [IT_W-1:0]   iter;
    logic [IT_W-1:0]   vote;
    logic [BC_W-1:0]   bit_cnt;
    logic [RC_W-1:0]   raw_cnt;
    logic [ST_W-1:0]   settle_cnt;
    logic              first_bit;
    logic              second_bit;
    logic [RESP_W-1:0] resp_q;
    logic [OC_W-1:0]   ones_q;
    logic [RND_W-1:0]  rounds_q;
    logic              err_q;
`ifdef STABILITY_MASK_EN
    logic [RESP_W-1:0] mask_q;
`endif

    logic [IT_W-1:0]   iter_nxt;
    logic [BC_W-1:0]   bit_cnt_nxt;
    logic [RND_W-1:0]  rounds_nxt;
    logic              crp_bit;
    logic              unanimous;
    logic              pair_ok;
    logic [MSB_W:0]    l_sum;
    logic [MSB_W-1:0]  l_sat;
    logic [MSB_W-1:0]  r_sat;
    logic [CHAL_W-1:0] lfsr_nxt;

    assign iter_nxt    = iter + 1'b1;
    assign bit_cnt_nxt = bit_cnt + 1'b1;
    assign rounds_nxt  = rounds_q + 1'b1;
    assign crp_bit     = (vote > MAJ_C);
    assign unanimous   = (vote == '0) || (vote == ITER_C);
    assign pair_ok     = (first_bit != second_bit);
    assign lfsr_nxt    = {lfsr[CHAL_W-2:0], ~^(lfsr & LFSR_TAPS)};

    // Bias fields saturate rather than wrap so the tuning loop can't flip sign.
    assign l_sum = {1'b0, l_msb} + STEP_X;
    assign l_sat = l_sum[MSB_W] ? '1 : l_sum[MSB_W-1:0];
    assign r_sat = ({1'b0, r_msb} < STEP_X) ? '0 : (r_msb - STEP_M);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state      <= S_IDLE;
            run_crp    <= 1'b0;
            run_trng   <= 1'b0;
            lfsr       <= '0;
            l_msb      <= '0;
            r_msb      <= '1;
            iter       <= '0;
            vote       <= '0;
            bit_cnt    <= '0;
            raw_cnt    <= '0;
            settle_cnt <= '0;
            first_bit  <= 1'b0;
            second_bit <= 1'b0;
            resp_q     <= '0;
            ones_q     <= '0;
            rounds_q   <= '0;
            err_q      <= 1'b0;
`ifdef STABILITY_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        run_crp  <= ~bus.mode;
                        run_trng <= bus.mode;
                        lfsr     <= bus.seed;
                        resp_q   <= '0;
                        ones_q   <= '0;
                        rounds_q <= '0;
                        err_q    <= 1'b0;
                        bit_cnt  <= '0;
                        raw_cnt  <= '0;
                        iter     <= '0;
                        vote     <= '0;
`ifdef STABILITY_MASK_EN
                        mask_q   <= '0;
`endif
                        state    <= bus.mode ? S_TRIG : S_LOAD;
                    end
                end
                S_LOAD: begin
                    lfsr  <= lfsr_nxt;
                    iter  <= '0;
                    vote  <= '0;
                    state <= S_TRIG;
                end
                S_TRIG: begin
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (run_crp) begin
                        vote  <= vote + IT_W'(bus.puf_resp);
                        iter  <= iter_nxt;
                        state <= (iter_nxt == ITER_C) ? S_VOTE : S_TRIG;
                    end else begin
                        ones_q  <= ones_q + OC_W'(bus.puf_resp);
                        raw_cnt <= raw_cnt + 1'b1;
                        // raw_cnt still holds the pre-sample count: even means first of a pair
                        if (!raw_cnt[0]) begin
                            first_bit <= bus.puf_resp;
                            state     <= S_TRIG;
                        end else begin
                            second_bit <= bus.puf_resp;
                            state      <= S_PAIR;
                        end
                    end
                end
                S_VOTE: begin
                    resp_q  <= {crp_bit, resp_q[RESP_W-1:1]};
                    ones_q  <= ones_q + OC_W'(crp_bit);
                    bit_cnt <= bit_cnt_nxt;
`ifdef STABILITY_MASK_EN
                    mask_q  <= {unanimous, mask_q[RESP_W-1:1]};
`endif
                    state   <= (bit_cnt_nxt == RESP_C) ? S_HOLD : S_LOAD;
                end
                S_PAIR: begin
                    if (pair_ok) begin
                        resp_q  <= {first_bit, resp_q[RESP_W-1:1]};
                        bit_cnt <= bit_cnt_nxt;
`ifdef STABILITY_MASK_EN
                        mask_q  <= {1'b0, mask_q[RESP_W-1:1]};
`endif
                    end
                    if (pair_ok && (bit_cnt_nxt == RESP_C)) begin
                        state <= S_HOLD;
                    end else if (raw_cnt == RAW_C) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_TRIG;
                    end
                end
                S_CHECK: begin
                    rounds_q <= rounds_nxt;
                    if (ones_q > BIAS_HI_C) begin
                        l_msb <= l_sat;
                    end else if (ones_q < BIAS_LO_C) begin
                        r_msb <= r_sat;
                    end
                    raw_cnt <= '0;
                    ones_q  <= '0;
                    if (rounds_nxt == MAXR_C) begin
                        err_q <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        state <= S_TRIG;
                    end
                end
                S_HOLD: begin
                    if (bus.resp_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Challenge mux follows the last run's mode; before any run only the right
    // arm carries the bias field.
    assign bus.puf_chal_l = run_crp  ? lfsr :
                            run_trng ? {l_msb, bus.trng_lsb} : '0;
    assign bus.puf_chal_r = run_crp  ? lfsr : {r_msb, bus.trng_lsb};

    assign bus.puf_trig   = (state == S_TRIG);
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = (state == S_HOLD);
    assign bus.resp_out   = resp_q;
    assign bus.err        = err_q;
    assign bus.ones_count = ones_q;
    assign bus.rounds     = rounds_q;
    assign bus.state_dbg  = state;
`ifdef STABILITY_MASK_EN
    assign bus.stable_mask = mask_q;
`endif

endmodule

// File: tb/tb_puf_crp_trng_engine.sv
// Randomised bench for puf_crp_trng_engine against a sample-log reference model.
// Bias field narrowed to 8 bits and the round limit to 12 so saturation and timeout fit a short run.
module tb_puf_crp_trng_engine;
    localparam int RESP_W     = 64;
    localparam int CHAL_W     = 64;
    localparam int MSB_W      = 8;
    localparam int LSB_W      = CHAL_W - MSB_W;
    localparam int ITER       = 10;
    localparam int MAJ        = 5;
    localparam int RAW_BLK    = 64;
    localparam int BIAS_HI    = 40;
    localparam int BIAS_LO    = 30;
    localparam int STEP       = 50;
    localparam int MAX_ROUNDS = 12;
    localparam int BUDGET     = 20000;

    localparam int P_ZERO = 0;
    localparam int P_ONE  = 1;
    localparam int P_ALT  = 2;
    localparam int P_KOF  = 3;
    localparam int P_RND  = 4;

    logic mclk;
    logic rst;
    int   n_vec;
    int   n_err;

    puf_crp_trng_engine_if #(
        .RESP_W(RESP_W), .CHAL_W(CHAL_W), .MSB_W(MSB_W),
        .RAW_BLK(RAW_BLK), .MAX_ROUNDS(MAX_ROUNDS)
    ) bus ();

    puf_crp_trng_engine #(
        .RESP_W(RESP_W), .CHAL_W(CHAL_W), .MSB_W(MSB_W), .ITER(ITER), .MAJ(MAJ),
        .SETTLE(1), .RAW_BLK(RAW_BLK), .BIAS_HI(BIAS_HI), .BIAS_LO(BIAS_LO),
        .STEP(STEP), .MAX_ROUNDS(MAX_ROUNDS)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    // ---------------- clock / reset
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- PUF model: answers each trigger and logs what it saw
    int          pol;
    int          pol_k;
    int          eval_n;
    logic        drv_r;
    logic [63:0] log_l[$];
    logic [63:0] log_r[$];
    logic        log_resp[$];

    always @(negedge mclk) begin
        if (rst) begin
            bus.puf_resp = 1'b0;
        end else if (bus.puf_trig) begin
            case (pol)
                P_ZERO:  drv_r = 1'b0;
                P_ONE:   drv_r = 1'b1;
                P_ALT:   drv_r = eval_n[0];
                P_KOF:   drv_r = ((eval_n % ITER) < pol_k);
                default: drv_r = ($urandom_range(99) < pol_k);
            endcase
            log_l.push_back(bus.puf_chal_l);
            log_r.push_back(bus.puf_chal_r);
            log_resp.push_back(drv_r);
            bus.puf_resp = drv_r;
            eval_n++;
        end
    end

    // ---------------- scoreboard
    int m_l;
    int m_r;
    logic [63:0] taps;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        return {x[62:0], ~^(x & taps)};
    endfunction

    task automatic check_crp(input logic [63:0] seed);
        logic [63:0] l;
        logic [63:0] e_resp;
        logic [63:0] e_mask;
        int          ones;
        int          idx;
        int          v;
        l = seed; e_resp = '0; e_mask = '0; ones = 0; idx = 0;
        chk("crp_trig_count", 64'(log_resp.size()), 64'(RESP_W * ITER));
        for (int b = 0; b < RESP_W; b++) begin
            l = lfsr_step(l);
            v = 0;
            for (int e = 0; e < ITER; e++) begin
                if (idx < log_resp.size()) begin
                    chk("crp_chal_l", log_l[idx], l);
                    chk("crp_chal_r", log_r[idx], l);
                    v += int'(log_resp[idx]);
                end
                idx++;
            end
            e_resp = {(v > MAJ), e_resp[63:1]};
            e_mask = {(v == 0 || v == ITER), e_mask[63:1]};
            ones += (v > MAJ) ? 1 : 0;
        end
        chk("crp_resp_out", bus.resp_out, e_resp);
        chk("crp_ones_count", 64'(bus.ones_count), 64'(ones));
        chk("crp_rounds", 64'(bus.rounds), 64'd0);
        chk("crp_err", 64'(bus.err), 64'd0);
`ifdef STABILITY_MASK_EN
        chk("crp_stable_mask", bus.stable_mask, e_mask);
`endif
    endtask

    task automatic check_trng(input logic [LSB_W-1:0] lsb);
        int          ones, raw, acc, rnd, i;
        logic        first, r, done, e_err;
        logic [63:0] e_resp;
        ones = 0; raw = 0; acc = 0; rnd = 0; i = 0;
        first = 1'b0; done = 1'b0; e_err = 1'b0; e_resp = '0;
        while (!done && i < log_resp.size()) begin
            chk("trng_chal_l", log_l[i], {8'(m_l), lsb});
            chk("trng_chal_r", log_r[i], {8'(m_r), lsb});
            r = log_resp[i];
            ones += int'(r);
            raw++;
            if (raw % 2 == 1) begin
                first = r;
            end else begin
                if (first != r) begin
                    e_resp = {first, e_resp[63:1]};
                    acc++;
                end
                if (acc == RESP_W) begin
                    done = 1'b1;
                end else if (raw == RAW_BLK) begin
                    rnd++;
                    if (ones > BIAS_HI) m_l = (m_l + STEP > 255) ? 255 : m_l + STEP;
                    else if (ones < BIAS_LO) m_r = (m_r - STEP < 0) ? 0 : m_r - STEP;
                    ones = 0;
                    raw  = 0;
                    if (rnd == MAX_ROUNDS) begin
                        e_err = 1'b1;
                        done  = 1'b1;
                    end
                end
            end
            i++;
        end
        chk("trng_model_done", 64'(done), 64'd1);
        chk("trng_trig_count", 64'(log_resp.size()), 64'(i));
        chk("trng_resp_out", bus.resp_out, e_resp);
        chk("trng_ones_count", 64'(bus.ones_count), 64'(ones));
        chk("trng_rounds", 64'(bus.rounds), 64'(rnd));
        chk("trng_err", 64'(bus.err), 64'(e_err));
`ifdef STABILITY_MASK_EN
        chk("trng_stable_mask", bus.stable_mask, 64'd0);
`endif
    endtask

    // ---------------- driver tasks
    task automatic apply_reset();
        @(negedge mclk);
        rst = 1'b1;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        m_l = 0;
        m_r = 255;
    endtask

    task automatic do_run(input logic m, input logic [63:0] sd, input int p, input int k,
                          output int lat);
        log_l.delete(); log_r.delete(); log_resp.delete();
        pol = p; pol_k = k; eval_n = 0;
        @(negedge mclk);
        bus.mode  = m;
        bus.seed  = sd;
        bus.start = 1'b1;
        @(posedge mclk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < BUDGET) begin
            @(posedge mclk);
            #1 lat++;
        end
        if (!bus.resp_valid) chk("run_timeout", 64'(bus.resp_valid), 64'd1);
    endtask

    task automatic ack_run();
        repeat (2) @(negedge mclk);
        chk("hold_valid", 64'(bus.resp_valid), 64'd1);
        bus.resp_ack = 1'b1;
        @(posedge mclk);
        #1 bus.resp_ack = 1'b0;
        chk("ack_busy", 64'(bus.busy), 64'd0);
        chk("ack_valid_drop", 64'(bus.resp_valid), 64'd0);
    endtask

    // ---------------- stimulus
    logic [LSB_W-1:0] lsb;
    int               lat;

    initial begin
        n_vec = 0; n_err = 0;
        taps = 64'hD800_0000_0000_0000;
        rst = 1'b1;
        pol = P_ZERO; pol_k = 0; eval_n = 0;
        lsb = {$urandom(), $urandom()};
        bus.start = 1'b0; bus.mode = 1'b0; bus.seed = '0; bus.resp_ack = 1'b0;
        bus.trng_lsb = lsb;
        apply_reset();

        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_resp_out", bus.resp_out, 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_trig", 64'(bus.puf_trig), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_ones", 64'(bus.ones_count), 64'd0);
        chk("rst_rounds", 64'(bus.rounds), 64'd0);
        chk("rst_chal_l", bus.puf_chal_l, 64'd0);
        chk("rst_chal_r", bus.puf_chal_r, {8'hFF, lsb});

        // CRP: stuck-at-one PUF, known seed, full-run latency
        do_run(1'b0, 64'h1, P_ONE, 0, lat);
        chk("crp_latency", 64'(lat), 64'(RESP_W * (1 + ITER * 3 + 1)));
        check_crp(64'h1);
        chk("crp_all_ones", bus.resp_out, 64'hFFFF_FFFF_FFFF_FFFF);
        ack_run();

        // CRP: majority boundary, 6 of 10 then 5 of 10
        begin
            logic [63:0] sd;
            sd = {$urandom(), $urandom()};
            do_run(1'b0, sd, P_KOF, 6, lat);
            check_crp(sd);
            ack_run();
            sd = {$urandom(), $urandom()};
            do_run(1'b0, sd, P_KOF, 5, lat);
            check_crp(sd);
            chk("crp_5of10_zero", bus.resp_out, 64'd0);
            ack_run();
            for (int n = 0; n < 2; n++) begin
                sd = {$urandom(), $urandom()};
                do_run(1'b0, sd, P_RND, 50, lat);
                check_crp(sd);
                ack_run();
            end
        end

        // TRNG: alternating 0,1 -> every pair rejects nothing and yields 0
        do_run(1'b1, 64'd0, P_ALT, 0, lat);
        @(negedge mclk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge mclk);
        bus.start = 1'b0;
        chk("hold_start_ignored", 64'(bus.resp_valid), 64'd1);
        check_trng(lsb);
        chk("alt_rounds", 64'(bus.rounds), 64'd1);
        chk("alt_raw_samples", 64'(log_resp.size()), 64'd128);
        @(negedge mclk);
        bus.start = 1'b1;
        bus.resp_ack = 1'b1;
        @(posedge mclk);
        #1 bus.start = 1'b0;
        bus.resp_ack = 1'b0;
        chk("ack_start_same_cycle", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge mclk);
        chk("start_not_captured", 64'(bus.busy), 64'd0);

        // TRNG: stuck one -> L saturates, timeout
        do_run(1'b1, 64'd0, P_ONE, 0, lat);
        check_trng(lsb);
        chk("stuck1_err", 64'(bus.err), 64'd1);
        chk("stuck1_l_sat", 64'(bus.puf_chal_l[63:56]), 64'hFF);
        ack_run();

        // TRNG: stuck zero -> R saturates at 0, L persists
        do_run(1'b1, 64'd0, P_ZERO, 0, lat);
        check_trng(lsb);
        chk("stuck0_r_sat", 64'(bus.puf_chal_r[63:56]), 64'h00);
        chk("stuck0_l_kept", 64'(bus.puf_chal_l[63:56]), 64'hFF);
        ack_run();

        // reset restores the bias fields
        apply_reset();
        chk("rst2_chal_r", bus.puf_chal_r, {8'hFF, lsb});
        chk("rst2_chal_l", bus.puf_chal_l, 64'd0);

        // TRNG: biased random sources after reset
        for (int n = 0; n < 3; n++) begin
            lsb = {$urandom(), $urandom()};
            bus.trng_lsb = lsb;
            do_run(1'b1, 64'd0, P_RND, (n == 0) ? 70 : (n == 1) ? 30 : 50, lat);
            check_trng(lsb);
            ack_run();
        end

        // ack outside HOLD ignored, then rst mid CRP run
        pol = P_ONE; eval_n = 0;
        @(negedge mclk);
        bus.mode = 1'b0; bus.seed = 64'h5; bus.start = 1'b1;
        @(negedge mclk);
        bus.start = 1'b0;
        repeat (100) @(negedge mclk);
        bus.resp_ack = 1'b1;
        @(negedge mclk);
        bus.resp_ack = 1'b0;
        chk("ack_outside_hold", 64'(bus.busy), 64'd1);
        repeat (100) @(negedge mclk);
        chk("mid_partial_resp", 64'(bus.resp_out != '0), 64'd1);
        rst = 1'b1;
        @(posedge mclk);
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_resp", bus.resp_out, 64'd0);
        chk("mid_rst_trig", 64'(bus.puf_trig), 64'd0);
        @(negedge mclk);
        rst = 1'b0;
        m_l = 0;
        m_r = 255;
        do_run(1'b1, 64'd0, P_RND, 60, lat);
        check_trng(lsb);
        ack_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/puf_crp_trng_engine.md
Name: puf_crp_trng_engine

Overview:
- Parametrised next-generation controller for the delay-based PUF core; the PUF core itself is external.
- Two modes: CRP (LFSR-generated challenges, majority-voted response bits) and TRNG (raw pair sampling, von Neumann debiasing, closed-loop bias tuning of challenge MSBs).
- Adds over the previous generation: start/busy/valid/ack handshake, configurable widths, depths and LFSR taps, bias-register saturation, and a round-limit timeout with error flag.

Parameters:
- RESP_W, 64, response / TRNG output bits per run.
- CHAL_W, 64, challenge width.
- MSB_W, 16, width of TRNG bias field (challenge MSBs).
- ITER, 10, PUF evaluations per CRP bit.
- MAJ, 5, CRP bit = 1 iff ones-count > MAJ.
- SETTLE, 1, wait cycles between trigger and sample (>=1).
- LFSR_TAPS, 64'hD800_0000_0000_0000, XNOR feedback tap mask.
- RAW_BLK, 64, raw TRNG samples per bias-check block (even).
- BIAS_HI, 40, raw ones above this in a block -> L_msb += STEP.
- BIAS_LO, 30, raw ones below this in a block -> R_msb -= STEP.
- STEP, 50, bias adjust step.
- MAX_ROUNDS, 1023, TRNG blocks before timeout.

Ports:
- mclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request; sampled only in IDLE
- mode  in  1  0 = CRP, 1 = TRNG; latched with start
- seed  in  CHAL_W  initial LFSR value; latched with start
- trng_lsb  in  CHAL_W-MSB_W  fixed TRNG challenge LSBs
- puf_trig  out  1  one-cycle PUF launch pulse
- puf_chal_l  out  CHAL_W  left challenge
- puf_chal_r  out  CHAL_W  right challenge
- puf_resp  in  1  PUF arbiter output, valid SETTLE cycles after puf_trig
- busy  out  1  high in every state except IDLE
- resp_out  out  RESP_W  result, MSB-first shift register (new bit enters at MSB, shifts right)
- resp_valid  out  1  result held valid
- resp_ack  in  1  consumer accept
- err  out  1  TRNG timeout; valid with resp_valid
- ones_count  out  $clog2(RAW_BLK+1)  CRP: voted ones in run; TRNG: raw ones in current block
- rounds  out  $clog2(MAX_ROUNDS+1)  TRNG blocks consumed

Behaviour:
- Reset (sync): state IDLE. All outputs 0, except puf_chal_r = {all-ones, trng_lsb}. L_msb = 0, R_msb = all-ones.
- L_msb / R_msb are cleared only by rst and persist across runs.
- Any state returns to IDLE on rst.
- IDLE: on start, latch mode and seed. Clear resp_out, counters and err. Go to LOAD (CRP) or TRIG (TRNG).
- CRP challenge: puf_chal_l = puf_chal_r = lfsr.
- TRNG challenge: puf_chal_l = {L_msb, trng_lsb}; puf_chal_r = {R_msb, trng_lsb}.
- LOAD (CRP only): lfsr <= {lfsr[CHAL_W-2:0], ~^(lfsr & LFSR_TAPS)}; clear iter and vote counters -> TRIG.
- TRIG: puf_trig = 1 for exactly this cycle -> SETTLE.
- SETTLE: SETTLE cycles -> SAMPLE.
- SAMPLE, CRP: vote += puf_resp; iter++. If iter == ITER -> VOTE, else -> TRIG.
- VOTE: bit = (vote > MAJ); shift bit into resp_out; ones_count += bit; bit_cnt++. If bit_cnt == RESP_W -> HOLD, else -> LOAD.
- SAMPLE, TRNG: store raw bit; ones_count += puf_resp; raw_cnt++.
  - Odd raw sample -> TRIG.
  - Even raw sample -> PAIR.
- PAIR, pair (first, second):
  - 01 -> shift 0 into resp_out, acc++.
  - 10 -> shift 1 into resp_out, acc++.
  - 00/11 -> discard.
  - Next state: if acc == RESP_W -> HOLD; else if raw_cnt == RAW_BLK -> CHECK; else -> TRIG.
- CHECK (one cycle): rounds++.
  - ones_count > BIAS_HI: L_msb += STEP, saturating at all-ones.
  - ones_count < BIAS_LO: R_msb -= STEP, saturating at 0.
  - Otherwise no change.
  - Clear raw_cnt and ones_count.
  - If rounds reaches MAX_ROUNDS: err = 1 -> HOLD (partial resp_out kept). Else -> TRIG.
- HOLD: resp_valid = 1; resp_out, err, ones_count stable. On resp_ack -> IDLE; resp_valid drops next cycle. resp_ack outside HOLD is ignored.
- start while busy is ignored. start and resp_ack in the same HOLD cycle: ack is taken; start is not captured.
- CRP latency per run: RESP_W * (1 + ITER*(SETTLE+2) + 1) cycles from IDLE exit to HOLD.

Optional Feature:
- Macro: STABILITY_MASK_EN.
- Defined:
  - Extra output stable_mask [RESP_W], shifted alongside resp_out in VOTE.
  - Mask bit = 1 iff vote == 0 or vote == ITER (unanimous).
  - Reset and IDLE-start value 0.
  - In TRNG mode, shifts 0 for each accepted bit.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- CRP, SETTLE=1, puf_resp stuck 1, seed=64'h1 -> HOLD after 64*(1+30+1)=2048 cycles; resp_out=all-ones, ones_count=64, 640 puf_trig pulses. With STABILITY_MASK_EN, stable_mask=all-ones.
- CRP, puf_resp 1 on 6 of 10 evaluations per bit -> all bits 1. Then 5 of 10 -> all bits 0 (strict >). LFSR sequence matches the XNOR model from seed.
- TRNG, puf_resp alternating 0,1 -> every pair is 01; resp_out=0 after 128 raw samples; rounds=1; resp_valid held until resp_ack, then IDLE.
- TRNG, puf_resp stuck 1 -> no accepted bits; each CHECK adds 50 to L_msb (64>40), saturating at 16'hFFFF. After 1023 blocks err=1, resp_valid=1.
- TRNG, puf_resp stuck 0 -> R_msb decrements by 50 per block, saturates at 0. Subsequent rst restores R_msb=16'hFFFF, L_msb=0.
- rst asserted mid-CRP run -> next cycle busy=0, resp_out=0, puf_trig=0. start in HOLD is ignored until resp_ack.
